// File: rtl/ldl_fifo_burst_rd.sv
// FWFT FIFO read-side burst drainer with a registered 2-entry skid output.
// Define LDL_FIFO_BURST_RD_TIMEOUT_EN to flush short bursts after TO idle cycles.
module ldl_fifo_burst_rd #(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int BL = 4,
    parameter int TO = 64,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_empty,
    input  logic [DW-1:0] f_dout,
    input  logic [AW-1:0] f_rcnt,
    output logic          f_re,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_sop,
    output logic          o_eop
);

    if (BL < 1 || BL > (1 << AW) - 1) begin : g_bl_chk
        $error("ldl_fifo_burst_rd: BL out of range");
    end
    if (TO < 1 || TO > (1 << TW) - 1) begin : g_to_chk
        $error("ldl_fifo_burst_rd: TO out of range");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [AW-1:0] rem;
    logic          first;
    logic [1:0]    occ;
    logic [1:0]    occ_nxt;
    logic [DW-1:0] sk_data;
    logic          sk_sop;
    logic          sk_eop;
    logic          pop;
    logic          deq;
    logic          full_go;
    logic          in_sop;
    logic          in_eop;

    assign full_go = ~f_empty & (f_rcnt >= AW'(BL));
    // occ is registered, so o_ready never reaches f_re combinationally
    assign f_re    = (state == BURST) & ~f_empty & (rem != '0) & (occ != 2'd2);
    assign pop     = f_re;
    assign deq     = o_valid & o_ready;
    assign occ_nxt = occ + {1'b0, pop} - {1'b0, deq};
    assign in_sop  = first;
    assign in_eop  = (rem == AW'(1));

`ifdef LDL_FIFO_BURST_RD_TIMEOUT_EN
    logic [TW-1:0] tcnt;
    logic          to_go;

    assign to_go = ~f_empty & (tcnt == TW'(TO - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            first <= 1'b0;
`ifdef LDL_FIFO_BURST_RD_TIMEOUT_EN
            tcnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Full burst takes priority over a coincident timeout
                    if (full_go) begin
                        rem   <= AW'(BL);
                        first <= 1'b1;
                        state <= BURST;
`ifdef LDL_FIFO_BURST_RD_TIMEOUT_EN
                        tcnt  <= '0;
                    end else if (to_go) begin
                        rem   <= (f_rcnt == '0) ? AW'(1) : f_rcnt;
                        first <= 1'b1;
                        state <= BURST;
                        tcnt  <= '0;
                    end else if (f_empty) begin
                        tcnt <= '0;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                BURST: begin
                    if (pop) begin
                        rem   <= rem - 1'b1;
                        first <= 1'b0;
                        if (in_eop) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            sk_data <= '0;
            sk_sop  <= 1'b0;
            sk_eop  <= 1'b0;
        end else begin
            occ     <= occ_nxt;
            o_valid <= (occ_nxt != 2'd0);
            // Head refills from skid when full, else from the FIFO when free
            if (occ == 2'd2) begin
                if (deq) begin
                    o_data <= sk_data;
                    o_sop  <= sk_sop;
                    o_eop  <= sk_eop;
                end
            end else if (pop && (occ == 2'd0 || deq)) begin
                o_data <= f_dout;
                o_sop  <= in_sop;
                o_eop  <= in_eop;
            end else if (pop) begin
                sk_data <= f_dout;
                sk_sop  <= in_sop;
                sk_eop  <= in_eop;
            end
        end
    end

endmodule

// File: tb/tb_ldl_fifo_burst_rd.sv
// Directed bench for ldl_fifo_burst_rd with a behavioural FWFT FIFO on its read port.
module tb_ldl_fifo_burst_rd;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int BL = 4;
    localparam int TO = 16;
    localparam int TW = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          f_empty = 1'b1;
    logic [DW-1:0] f_dout  = '0;
    logic [AW-1:0] f_rcnt  = '0;
    logic          f_re;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic [DW-1:0] o_data;
    logic          o_sop;
    logic          o_eop;

    ldl_fifo_burst_rd #(
        .DW(DW),
        .AW(AW),
        .BL(BL),
        .TO(TO),
        .TW(TW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .f_empty(f_empty),
        .f_dout (f_dout),
        .f_rcnt (f_rcnt),
        .f_re   (f_re),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_sop  (o_sop),
        .o_eop  (o_eop)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // FIFO model: pops on f_re, absorbs queued writes, updates outputs after the edge
    logic [DW-1:0] q[$];
    logic [DW-1:0] wq[$];
    logic          fifo_clr = 1'b0;

    initial forever begin
        @(posedge clk);
        if (f_re && q.size() != 0) void'(q.pop_front());
        if (fifo_clr) q.delete();
        while (wq.size() != 0) q.push_back(wq.pop_front());
        f_empty <= (q.size() == 0);
        f_dout  <= (q.size() != 0) ? q[0] : '0;
        f_rcnt  <= (q.size() > 15) ? 4'hf : 4'(q.size());
    end

    // Monitor on the falling edge
    int         cyc = 0;
    int         fre_cyc[$];
    logic [9:0] rx[$];
    int         first_valid = -1;
    int         first_ne    = -1;
    int         valid_cnt   = 0;
    int         tb_occ      = 0;
    logic       prev_hold   = 1'b0;
    logic [9:0] prev_word   = '0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            tb_occ    = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", {o_valid, o_sop, o_eop, o_data}, {1'b1, prev_word});
            if (tb_occ == 2) chk("fre_when_full", f_re, 0);
            if (f_re) fre_cyc.push_back(cyc);
            if (o_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (!f_empty && first_ne < 0) first_ne = cyc;
            if (o_valid && o_ready) rx.push_back({o_sop, o_eop, o_data});
            prev_hold = o_valid && !o_ready;
            prev_word = {o_sop, o_eop, o_data};
            tb_occ    = tb_occ + (f_re ? 1 : 0) - ((o_valid && o_ready) ? 1 : 0);
        end
    end

    logic [9:0] exp_q[$];

    function automatic int fre_at(input int k);
        return (k < fre_cyc.size()) ? fre_cyc[k] : -1000;
    endfunction

    function automatic logic [31:0] rx_at(input int k);
        return (k < rx.size()) ? {22'd0, rx[k]} : 32'hfff;
    endfunction

    task automatic add_burst(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({k == 0, k == n - 1, base + 8'(k)});
    endtask

    task automatic push_words(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) wq.push_back(base + 8'(k));
    endtask

    task automatic start_test();
        rst_n    = 1'b0;
        o_ready  = 1'b1;
        fifo_clr = 1'b1;
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
        rx.delete();
        fre_cyc.delete();
        exp_q.delete();
        first_valid = -1;
        first_ne    = -1;
        valid_cnt   = 0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx.size() < n; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("rx_count", rx.size(), n);
    endtask

    task automatic check_seq(input string tag);
        for (int k = 0; k < exp_q.size(); k++) chk(tag, rx_at(k), {22'd0, exp_q[k]});
    endtask

    initial begin
        int offs[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
        int eops;

        // Reset hold with 5 words waiting
        #1 rst_n = 1'b0;
        push_words(8'h11, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_f_re", f_re, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_sop", o_sop, 0);
            chk("rst_eop", o_eop, 0);
        end
        chk("rst_data", o_data, 0);

        // Two full bursts, no backpressure
        start_test();
        push_words(8'ha1, 8);
        release_rst();
        wait_rx(8, 200);
        add_burst(8'ha1, 4);
        add_burst(8'ha5, 4);
        check_seq("full_word");
        chk("full_fre_count", fre_cyc.size(), 8);
        for (int k = 0; k < 8; k++) chk("full_fre_gap", fre_at(k) - fre_at(0), offs[k]);
        chk("full_latency", first_valid - fre_at(0), 1);

        // Alternating backpressure
        start_test();
        push_words(8'ha1, 8);
        release_rst();
        for (int i = 0; i < 200 && rx.size() < 8; i++) begin
            @(posedge clk);
            #1;
            o_ready = ~o_ready;
        end
        o_ready = 1'b1;
        wait_rx(8, 20);
        add_burst(8'ha1, 4);
        add_burst(8'ha5, 4);
        check_seq("bp_word");
        chk("bp_fre_count", fre_cyc.size(), 8);

`ifdef LDL_FIFO_BURST_RD_TIMEOUT_EN
        // Short burst flushed by timeout
        start_test();
        release_rst();
        @(posedge clk);
        #1;
        push_words(8'hb1, 3);
        wait_rx(3, 100);
        add_burst(8'hb1, 3);
        check_seq("to_word");
        chk("to_fre_count", fre_cyc.size(), 3);
        chk("to_delay", fre_at(0) - first_ne, 16);

        // Fourth word lands in the same cycle the timeout fires
        start_test();
        release_rst();
        @(posedge clk);
        #1;
        push_words(8'hc1, 3);
        repeat (15) @(posedge clk);
        #1;
        push_words(8'hc4, 1);
        wait_rx(4, 100);
        add_burst(8'hc1, 4);
        check_seq("tie_word");
        chk("tie_fre_count", fre_cyc.size(), 4);
        chk("tie_delay", fre_at(0) - first_ne, 16);
`else
        // Without timeout, a short FIFO is never drained
        start_test();
        release_rst();
        @(posedge clk);
        #1;
        push_words(8'hb1, 3);
        repeat (100) @(posedge clk);
        #1;
        chk("noto_valid_cycles", valid_cnt, 0);
        chk("noto_fre_count", fre_cyc.size(), 0);
`endif

        // Reset after two of four words popped
        start_test();
        push_words(8'hd1, 4);
        release_rst();
        for (int i = 0; i < 50 && fre_cyc.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_valid", o_valid, 0);
        chk("abort_sop", o_sop, 0);
        chk("abort_eop", o_eop, 0);
        chk("abort_data", o_data, 0);
        chk("abort_f_re", f_re, 0);
        chk("abort_pops", fre_cyc.size(), 2);
        chk("abort_rx_count", rx.size(), 1);
        chk("abort_rx0", rx_at(0), {22'd0, 1'b1, 1'b0, 8'hd1});
        eops = 0;
        foreach (rx[k]) if (rx[k][8]) eops++;
        chk("abort_no_eop", eops, 0);

        start_test();
        push_words(8'he1, 4);
        release_rst();
        wait_rx(4, 100);
        add_burst(8'he1, 4);
        check_seq("after_abort_word");
        chk("after_abort_fre_count", fre_cyc.size(), 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
